// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts decoded MIPS fields over valid/ready,
// packs them into 32-bit words and writes them at consecutive addresses.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_fmt,
    input  logic [5:0]    in_ctrl,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [5:0]    in_function,
    input  logic [25:0]   in_jump,
    input  logic [15:0]   in_sign_ext,
    input  logic          in_last,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0]    FMT_R   = 2'b00;
    localparam logic [1:0]    FMT_I   = 2'b01;
    localparam logic [1:0]    FMT_J   = 2'b10;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t        state_r;
    logic [31:0]   base_r;
    logic [CW-1:0] count_r;
    logic          error_r;
    logic          wr_en_r;
    logic [31:0]   wr_addr_r;
    logic [31:0]   wr_data_r;

    logic          accept_s;
    logic          legal_s;
    logic [CW-1:0] count_inc_s;
    logic [31:0]   addr_s;
    logic [31:0]   packed_s;

    // Field packing by instruction format; fields not in the format are ignored.
    function automatic logic [31:0] pack_word(
        input logic [1:0]  fmt,
        input logic [5:0]  ctrl,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [25:0] jump,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (fmt)
            FMT_R:   word = {ctrl, rs, rt, rd, shamt, funct};
            FMT_I:   word = {ctrl, rs, rt, imm};
            FMT_J:   word = {ctrl, jump};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Handshake qualification, next word address and packed data.
    always_comb begin
        accept_s    = in_valid && (state_r == LOAD);
        legal_s     = (in_fmt == FMT_R) || (in_fmt == FMT_I) || (in_fmt == FMT_J);
        count_inc_s = count_r + CW'(1);
        addr_s      = base_r + {{(32 - CW){1'b0}}, count_r};
        packed_s    = pack_word(in_fmt, in_ctrl, in_rs, in_rt, in_rd, in_shamt,
                                in_function, in_jump, in_sign_ext);
    end

    // Session FSM with write-port registers; start overrides any same-cycle accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            base_r    <= 32'h0000_0000;
            count_r   <= {CW{1'b0}};
            error_r   <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 32'h0000_0000;
            wr_data_r <= 32'h0000_0000;
        end else begin
            wr_en_r <= 1'b0;
            if (start) begin
                state_r <= LOAD;
                base_r  <= base_addr;
                count_r <= {CW{1'b0}};
                error_r <= 1'b0;
            end else begin
                case (state_r)
                    LOAD: begin
                        if (accept_s && !legal_s) begin
                            error_r <= 1'b1;
                            state_r <= DONE;
                        end else if (accept_s) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= addr_s;
                            wr_data_r <= packed_s;
                            count_r   <= count_inc_s;
                            // Leaving LOAD at DEPTH is what saturates the counter.
                            if (in_last || (count_inc_s == DEPTH_C)) begin
                                state_r <= DONE;
                            end else begin
                                state_r <= LOAD;
                            end
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                    IDLE:    state_r <= IDLE;
                    DONE:    state_r <= DONE;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = (state_r == LOAD);
    assign busy       = (state_r == LOAD);
    assign done       = (state_r == DONE);
    assign error      = error_r;
    assign word_count = count_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random load sessions checked against a
// program-level model of the expected write sequence.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fmt;
    logic [5:0]    in_ctrl;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]    in_function;
    logic [25:0]   in_jump;
    logic [15:0]   in_sign_ext;
    logic          in_last;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] word_count;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_function(in_function), .in_jump(in_jump),
        .in_sign_ext(in_sign_ext), .in_last(in_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  ctrl;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [25:0] jmp;
        logic [15:0] imm;
        logic        last;
    } bundle_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bundle_t     prog[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture every write strobe seen on the memory port.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    function automatic logic [31:0] model_word(input bundle_t b);
        logic [31:0] w;
        w = 32'(b.ctrl) * 32'd67108864;
        if (b.fmt == 2'd0)
            w = w + 32'(b.rs) * 32'd2097152 + 32'(b.rt) * 32'd65536
                  + 32'(b.rd) * 32'd2048 + 32'(b.sh) * 32'd64 + 32'(b.fn);
        else if (b.fmt == 2'd1)
            w = w + 32'(b.rs) * 32'd2097152 + 32'(b.rt) * 32'd65536 + 32'(b.imm);
        else
            w = w + 32'(b.jmp);
        return w;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got_data.size()) return got_data[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.fmt  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        b.ctrl = 6'($urandom);
        b.rs   = 5'($urandom);
        b.rt   = 5'($urandom);
        b.rd   = 5'($urandom);
        b.sh   = 5'($urandom);
        b.fn   = 6'($urandom);
        b.jmp  = 26'($urandom);
        b.imm  = 16'($urandom);
        b.last = 1'b0;
        return b;
    endfunction

    function automatic bundle_t mk(input logic [1:0] fmt, input logic [5:0] ctrl,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] sh,
                                   input logic [5:0] fn, input logic [25:0] jmp,
                                   input logic [15:0] imm, input logic last);
        bundle_t b;
        b.fmt = fmt; b.ctrl = ctrl; b.rs = rs; b.rt = rt; b.rd = rd; b.sh = sh;
        b.fn = fn; b.jmp = jmp; b.imm = imm; b.last = last;
        return b;
    endfunction

    task automatic drive_bundle(input bundle_t b);
        in_fmt = b.fmt; in_ctrl = b.ctrl; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
        in_shamt = b.sh; in_function = b.fn; in_jump = b.jmp; in_sign_ext = b.imm;
        in_last = b.last;
    endtask

    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        got_addr.delete();
        got_data.delete();
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the program in prog from base and compares the session outcome.
    task automatic run_session(input logic [31:0] base, input string tag);
        int k = 0;
        int consumed = 0;
        logic err = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        foreach (prog[i]) begin
            consumed++;
            if (prog[i].fmt == 2'b11) begin
                err = 1'b1;
                break;
            end
            exp_addr.push_back(base + 32'(k));
            exp_data.push_back(model_word(prog[i]));
            k++;
            if (prog[i].last || k == DEPTH) break;
        end
        do_start(base);
        check_eq({tag, "_error_cleared"}, 32'(error), 32'd0);
        for (int i = 0; i < consumed; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_bundle(prog[i]);
            in_valid = 1'b1;
            check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
        end
        check_eq({tag, "_done_with_last"}, 32'(done), 32'd1);
        check_eq({tag, "_wr_en_with_last"}, 32'(wr_en), 32'(!err));
        drive_bundle(mk(2'b00, 6'd1, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 26'd0, 16'd0, 1'b0));
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq({tag, "_in_ready_after"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_n_writes"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < got_data.size()) begin
                check_eq({tag, "_addr"}, got_addr[i], exp_addr[i]);
                check_eq({tag, "_data"}, got_data[i], exp_data[i]);
            end
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'(err));
        check_eq({tag, "_word_count"}, 32'(word_count), 32'(k));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0;
        drive_bundle(mk(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 16'd0, 1'b0));
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_addr", wr_addr, 32'h0);
        check_eq("rst_wr_data", wr_data, 32'h0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a stream discards the pending write.
        do_start(32'h40);
        drive_bundle(mk(2'b00, 6'd3, 5'd3, 5'd3, 5'd3, 5'd3, 6'd3, 26'd0, 16'd0, 1'b0));
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("midrst_wr_en", 32'(wr_en), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_word_count", 32'(word_count), 32'd0);
        check_eq("midrst_wr_addr", wr_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        prog.delete();
        prog.push_back(mk(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'd0, 16'd0, 1'b1));
        run_session(32'h10, "rtype");
        check_eq("rtype_word", got_at(0), 32'h0022_1820);

        prog.delete();
        prog.push_back(mk(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 26'd0, 16'hFFFF, 1'b0));
        prog.push_back(mk(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 26'h0000040, 16'd0, 1'b1));
        run_session(32'h10, "ij");
        check_eq("ij_word0", got_at(0), 32'h2022_FFFF);
        check_eq("ij_word1", got_at(1), 32'h0800_0040);

        prog.delete();
        prog.push_back(mk(2'b00, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h21, 26'd0, 16'd0, 1'b0));
        prog.push_back(mk(2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 26'd0, 16'd0, 1'b0));
        run_session(32'h100, "illegal");

        prog.delete();
        for (int i = 0; i < 6; i++) begin
            prog.push_back(mk(2'b01, 6'(i), 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'd0, 16'(i), 1'b0));
        end
        run_session(32'h200, "depth");

        prog.delete();
        prog.push_back(mk(2'b10, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF, 16'd0, 1'b0));
        prog.push_back(mk(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h1234567, 16'd0, 1'b1));
        run_session(32'hFFFF_FFFF, "wrap");

        // Start coincident with an accept drops that bundle.
        do_start(32'h20);
        drive_bundle(mk(2'b00, 6'h01, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 26'd0, 16'd0, 1'b0));
        in_valid  = 1'b1;
        start     = 1'b1;
        base_addr = 32'h30;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("startacc_writes", 32'(got_data.size()), 32'd0);
        check_eq("startacc_word_count", 32'(word_count), 32'd0);
        check_eq("startacc_busy", 32'(busy), 32'd1);
        drive_bundle(mk(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0000055, 16'd0, 1'b1));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("startacc_addr", wr_addr, 32'h30);
        check_eq("startacc_data", wr_data, 32'h0800_0055);

        for (int s = 0; s < 20; s++) begin
            int n = $urandom_range(1, 6);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_bundle());
            prog[n - 1].last = 1'b1;
            if ($urandom_range(0, 3) == 0) prog[$urandom_range(0, n - 1)].last = 1'b1;
            run_session($urandom, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential write-side companion to the instruction memory. Accepts decoded instruction fields (opcode, rs, rt, rd, shamt, function, jump target, immediate) over a valid/ready stream, packs them into 32-bit MIPS words by format, and drives the memory write port at consecutive word addresses from a programmable base. Used by the test harness and boot path to program instruction memory without `$readmemb`.

## Interface
- DEPTH, 1024: maximum words written per load session.
- CW, derived as ceil(log2(DEPTH+1)) (11 for default): width of word counter.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches base_addr, clears counter, enters LOAD.
- base_addr  in  32  word address of first write.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_fmt  in  2  00 R-type, 01 I-type, 10 J-type, 11 illegal.
- in_ctrl  in  6  opcode.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_function  in  6  funct field.
- in_jump  in  26  jump target.
- in_sign_ext  in  16  immediate.
- in_last  in  1  bundle is last of program.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  32  word address.
- wr_data  out  32  packed instruction.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- error  out  1  sticky; illegal format received this session.
- word_count  out  CW  words written this session.

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- in_ready = (state == LOAD); busy same; done = (state == DONE).
- Accept = in_valid & in_ready at rising edge.
- Packing: R = {ctrl,rs,rt,rd,shamt,function}; I = {ctrl,rs,rt,sign_ext}; J = {ctrl,jump}. Unused fields ignored.
- Legal accept: register wr_data, wr_addr = base_addr_latched + word_count (mod 2^32), wr_en = 1 next cycle; word_count increments.
- Illegal accept (fmt 11): no write, error set, state -> DONE, word_count unchanged.
- LOAD -> DONE on legal accept with in_last = 1, or when incremented word_count == DEPTH.
- start: honoured in any state, priority over a same-cycle accept (that bundle dropped, no write). Clears word_count and error, latches base_addr, -> LOAD. A write registered on the previous edge still issues.
- DONE holds until start or reset; in_valid ignored in IDLE/DONE.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, word_count 0. Reset mid-LOAD aborts; pending write discarded.
- Accept-to-write latency: 1 cycle; throughput 1 word/cycle with in_valid held high.
- wr_en never high two cycles for one accept; wr_addr/wr_data hold last value when wr_en low.
- After final accept, in_ready drops the next cycle, coincident with the final wr_en pulse; done rises same cycle.
- Address wraps: base 0xFFFFFFFF, second word at 0x00000000.
- DEPTH boundary: at most DEPTH writes; word_count saturates at DEPTH.

## Test plan
- Reset mid-stream, then start base 0x10; R-type ctrl 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20 -> next cycle wr_en, wr_addr 0x10, wr_data 0x00221820.
- Back-to-back I (ctrl 0x08, rs 1, rt 2, imm 0xFFFF) then J last (ctrl 0x02, jump 0x0000040) -> wr_data 0x2022FFFF @0x10, 0x08000040 @0x11; done 1, in_ready 0, word_count 2.
- in_fmt 11 mid-stream after one legal word -> no wr_en, error 1, done 1, word_count 1; new start clears error.
- DEPTH 4, never assert in_last, stream 6 bundles -> exactly 4 writes, done after 4th, in_ready 0 from then.
- base 0xFFFFFFFF, two words -> addresses 0xFFFFFFFF, 0x00000000; start coincident with accept in LOAD -> bundle dropped, word_count 0.
